machine_timer_unit: RTL and testbench

MACHINE_TIMER_UNIT -- requirements
Module: machine_timer_unit

---
 rtl/machine_timer_unit.sv | 121 ++++++++++++
 tb/tb_machine_timer_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer_unit.sv
// Machine timer: free-running 64-bit mtime behind a prescaler, mtimecmp level
// interrupt, and a single-outstanding request/response register port.
module machine_timer_unit #(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        timer_timeout
);
  localparam logic [4:0] A_MTIME_LO = 5'h00;
  localparam logic [4:0] A_MTIME_HI = 5'h04;
  localparam logic [4:0] A_CMP_LO   = 5'h08;
  localparam logic [4:0] A_CMP_HI   = 5'h0C;
  localparam logic [4:0] A_CTRL     = 5'h10;

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_count_en;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_timeout;

  logic                  w_accept;
  logic                  w_addr_ok;
  logic                  w_wr;
  logic                  w_run;
  logic                  w_tick;
  logic [31:0]           w_rdata;
  logic [63:0]           w_mtime_nxt;
  logic [63:0]           w_mtimecmp_nxt;
  logic [PRESCALE_W-1:0] w_pcnt_nxt;

  assign req_ready     = !r_rsp_valid || rsp_ready;
  assign w_accept      = req_valid && req_ready;
  assign w_wr          = w_accept && req_write && w_addr_ok;
  assign w_run         = enable && r_count_en;
  assign w_tick        = w_run && (r_pcnt == r_prescale);

  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;
  assign timer_timeout = r_timeout;

  always_comb begin
    w_addr_ok = 1'b1;
    w_rdata   = '0;
    case (req_addr)
      A_MTIME_LO: w_rdata = r_mtime[31:0];
      A_MTIME_HI: w_rdata = r_mtime[63:32];
      A_CMP_LO:   w_rdata = r_mtimecmp[31:0];
      A_CMP_HI:   w_rdata = r_mtimecmp[63:32];
      A_CTRL:     w_rdata = (32'(r_prescale) << 8) | {31'b0, r_count_en};
      default:    w_addr_ok = 1'b0;
    endcase
  end

  // A bus write to either mtime half replaces that cycle's increment entirely.
  always_comb begin
    w_mtime_nxt    = w_tick ? (r_mtime + 64'd1) : r_mtime;
    w_mtimecmp_nxt = r_mtimecmp;
    w_pcnt_nxt     = r_pcnt;
    if (w_run) begin
      w_pcnt_nxt = w_tick ? '0 : (r_pcnt + PRESCALE_W'(1));
    end
    if (w_wr) begin
      case (req_addr)
        A_MTIME_LO: w_mtime_nxt    = {r_mtime[63:32], req_wdata};
        A_MTIME_HI: w_mtime_nxt    = {req_wdata, r_mtime[31:0]};
        A_CMP_LO:   w_mtimecmp_nxt = {r_mtimecmp[63:32], req_wdata};
        A_CMP_HI:   w_mtimecmp_nxt = {req_wdata, r_mtimecmp[31:0]};
        A_CTRL:     w_pcnt_nxt     = '0;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtime     <= '0;
      r_mtimecmp  <= CMP_RESET;
      r_prescale  <= '0;
      r_count_en  <= 1'b1;
      r_pcnt      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_timeout  <= (w_mtime_nxt >= w_mtimecmp_nxt);
      if (w_wr && (req_addr == A_CTRL)) begin
        r_prescale <= req_wdata[8 +: PRESCALE_W];
        r_count_en <= req_wdata[0];
      end
      // Response holds until consumed; a new accept may replace it in the same cycle.
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= req_write ? 32'h0 : w_rdata;
        r_rsp_err   <= !w_addr_ok;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_machine_timer_unit.sv
// Randomized bench for machine_timer_unit: a per-cycle reference model feeds a
// response scoreboard consumed by an independent monitor.
module tb_machine_timer_unit;
  localparam int PW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        timer_timeout;

  machine_timer_unit #(.PRESCALE_W(PW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .timer_timeout(timer_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic [PW-1:0] m_pre;
  logic [PW-1:0] m_pcnt;
  logic        m_cen;
  logic        m_rspv;
  logic        m_timeout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mtime   = 64'd0;
    m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
    m_pre     = '0;
    m_cen     = 1'b1;
    m_pcnt    = '0;
    m_rspv    = 1'b0;
    m_timeout = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cyc(input logic rv, input logic wr, input logic [4:0] a,
                     input logic [31:0] d, input logic en, input logic rr);
    logic        hit, acc, tick;
    logic [31:0] rd;
    logic [63:0] nt, nc;
    logic [PW-1:0] np;
    rsp_t        r;
    req_valid = rv; req_write = wr; req_addr = a; req_wdata = d;
    enable = en; rsp_ready = rr;
    #1;
    check("req_ready", req_ready, !m_rspv || rr);
    hit = (a inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10});
    case (a)
      5'h00:   rd = m_mtime[31:0];
      5'h04:   rd = m_mtime[63:32];
      5'h08:   rd = m_cmp[31:0];
      5'h0C:   rd = m_cmp[63:32];
      5'h10:   rd = {16'h0, m_pre, 7'h0, m_cen};
      default: rd = 32'h0;
    endcase
    acc  = rv && (!m_rspv || rr);
    tick = en && m_cen && (m_pcnt == m_pre);
    nt   = tick ? m_mtime + 64'd1 : m_mtime;
    nc   = m_cmp;
    np   = (en && m_cen) ? (tick ? '0 : m_pcnt + 8'd1) : m_pcnt;
    if (acc && wr && hit) begin
      case (a)
        5'h00: nt = {m_mtime[63:32], d};
        5'h04: nt = {d, m_mtime[31:0]};
        5'h08: nc = {m_cmp[63:32], d};
        5'h0C: nc = {d, m_cmp[31:0]};
        default: begin
          np    = '0;
          m_pre = d[15:8];
          m_cen = d[0];
        end
      endcase
    end
    if (acc) begin
      r.rdata = wr ? 32'h0 : rd;
      r.err   = !hit;
      exp_q.push_back(r);
    end
    m_rspv = acc ? 1'b1 : (rr ? 1'b0 : m_rspv);
    @(posedge clk); #1;
    m_mtime   = nt;
    m_cmp     = nc;
    m_pcnt    = np;
    m_timeout = (nt >= nc);
    check("timer_timeout", timer_timeout, m_timeout);
    check("rsp_valid", rsp_valid, m_rspv);
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d, input logic en);
    cyc(1'b1, 1'b1, a, d, en, 1'b1);
  endtask

  task automatic rd_reg(input logic [4:0] a, input logic en);
    cyc(1'b1, 1'b0, a, 32'h0, en, 1'b1);
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'h00, 32'h0, en, 1'b1);
  endtask

  // Reset is held for two edges while a write to mtime_lo is presented.
  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; req_valid = 1'b1; req_write = 1'b1;
    req_addr = 5'h00; req_wdata = $urandom | 32'h1; rsp_ready = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    m_reset();
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_timeout", timer_timeout, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
  endtask

  // Monitor: checks each response against the scoreboard head while presented.
  always @(negedge clk) begin
    if (reset !== 1'b1 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        check("rsp_err", rsp_err, exp_q[0].err);
        if (rsp_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    int          sel;
    reset = 1'b1; enable = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    m_reset();
    @(posedge clk); #1;
    do_reset();

    // Register contents straight out of reset, read without counting.
    rd_reg(5'h00, 1'b0); rd_reg(5'h04, 1'b0); rd_reg(5'h08, 1'b0);
    rd_reg(5'h0C, 1'b0); rd_reg(5'h10, 1'b0);

    // Compare at 10 with prescale 0.
    wr_reg(5'h0C, 32'h0, 1'b0);
    wr_reg(5'h08, 32'd10, 1'b0);
    idle(14, 1'b1);

    // Prescale 3, then frozen by enable low.
    wr_reg(5'h08, 32'hFFFF_0000, 1'b1);
    wr_reg(5'h10, 32'h0000_0301, 1'b1);
    idle(13, 1'b1);
    rd_reg(5'h00, 1'b1);
    idle(8, 1'b0);
    rd_reg(5'h00, 1'b0);

    // Carry from lo into hi, then full wrap with timeout falling.
    wr_reg(5'h10, 32'h0000_0001, 1'b0);
    wr_reg(5'h04, 32'h0, 1'b0);
    wr_reg(5'h00, 32'hFFFF_FFFF, 1'b0);
    idle(1, 1'b1);
    rd_reg(5'h04, 1'b0); rd_reg(5'h00, 1'b0);
    wr_reg(5'h08, 32'd5, 1'b0);
    wr_reg(5'h04, 32'hFFFF_FFFF, 1'b0);
    wr_reg(5'h00, 32'hFFFF_FFFF, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Timeout cleared by raising mtimecmp above mtime.
    wr_reg(5'h08, 32'd0, 1'b1);
    idle(2, 1'b1);
    wr_reg(5'h08, m_mtime[31:0] + 32'd100, 1'b1);
    idle(2, 1'b1);

    // Invalid address with response held off for three cycles.
    cyc(1'b1, 1'b0, 5'h14, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'h00, 32'h0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Write beats the tick it coincides with.
    wr_reg(5'h10, 32'h0000_0001, 1'b1);
    wr_reg(5'h00, 32'h50, 1'b1);
    rd_reg(5'h00, 1'b0);

    // Reset while a response is waiting.
    cyc(1'b1, 1'b0, 5'h04, 32'h0, 1'b1, 1'b0);
    do_reset();
    rd_reg(5'h00, 1'b0);

    for (int n = 0; n < 2500; n++) begin
      sel = int'($urandom_range(0, 99));
      a   = 5'($urandom_range(0, 4) * 4);
      if (sel < 5) a = 5'($urandom);
      d = $urandom_range(0, 300);
      if (a == 5'h04 || a == 5'h0C) d = ($urandom_range(0, 9) == 0) ? $urandom : 32'h0;
      if (a == 5'h10) d = (32'($urandom_range(0, 3)) << 8) | 32'(($urandom_range(0, 3) != 0));
      if (a == 5'h00 && $urandom_range(0, 19) == 0) d = 32'hFFFF_FFFF;
      cyc(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), a, d,
          ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0));
      if (n == 1200) do_reset();
    end

    idle(4, 1'b1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
